// File: rtl/sram_axi_arbiter_if.sv
// Single-beat AXI4 master/slave bundle shared by the SRAM arbiter and its interconnect.
// Master drives AR/AW/W and the R/B ready lines; slave drives the rest.
interface sram_axi_arbiter_if #(
    parameter int unsigned ADDR_WD = 64,
    parameter int unsigned DATA_WD = 64
);
    logic [3:0]           arid;
    logic [ADDR_WD-1:0]   araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 arready;

    logic [3:0]           rid;
    logic [DATA_WD-1:0]   rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    logic [3:0]           awid;
    logic [ADDR_WD-1:0]   awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;

    logic [DATA_WD-1:0]   wdata;
    logic [DATA_WD/8-1:0] wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [3:0]           bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_arbiter.sv
// Arbitrates instruction and data SRAM requests onto one single-beat AXI4 master port,
// one transaction at a time, buffering read data and stalling the pipeline until done.
module sram_axi_arbiter #(
    parameter int unsigned ADDR_WD = 64,
    parameter int unsigned DATA_WD = 64,
    parameter logic [3:0]  INST_ID = 4'd0,
    parameter logic [3:0]  DATA_ID = 4'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_sram_en,
    input  logic [ADDR_WD-1:0]   inst_sram_addr,
    output logic [DATA_WD-1:0]   inst_sram_rdata,
    input  logic                 data_sram_en,
    input  logic [DATA_WD/8-1:0] data_sram_we,
    input  logic [ADDR_WD-1:0]   data_sram_addr,
    input  logic [DATA_WD-1:0]   data_sram_wdata,
    output logic [DATA_WD-1:0]   data_sram_rdata,
    output logic                 stallreq_axi,
    output logic                 axi_err,
    sram_axi_arbiter_if.master   axi
);
    localparam int unsigned STRB_WD = DATA_WD / 8;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StB} state_e;

    state_e               state_q, state_d;
    logic [3:0]           req_id_q, req_id_d;
    logic [ADDR_WD-1:0]   req_addr_q, req_addr_d;
    logic [STRB_WD-1:0]   req_strb_q, req_strb_d;
    logic [DATA_WD-1:0]   req_wdata_q, req_wdata_d;
    logic                 req_data_q, req_data_d;  // owner of the in-flight request: 1 = data port
    logic                 ar_done_q, ar_done_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic [DATA_WD-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_WD-1:0]   data_rdata_q, data_rdata_d;
    logic                 inst_done_q, inst_done_d;
    logic                 data_done_q, data_done_d;
    logic                 axi_err_q, axi_err_d;

    logic inst_pend, data_pend, aw_ok, w_ok;
    logic unused_sigs;

    assign inst_pend    = inst_sram_en & ~inst_done_q;
    assign data_pend    = data_sram_en & ~data_done_q;
    assign stallreq_axi = (state_q != StIdle) | inst_pend | data_pend;

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign axi_err         = axi_err_q;

    assign axi.arid    = req_id_q;
    assign axi.araddr  = req_addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'b011;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = (state_q == StRd) & ~ar_done_q;
    assign axi.rready  = (state_q == StRd) & ar_done_q;

    assign axi.awid    = req_id_q;
    assign axi.awaddr  = req_addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'b011;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = (state_q == StWr) & ~aw_done_q;
    assign axi.wdata   = req_wdata_q;
    assign axi.wstrb   = req_strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state_q == StWr) & ~w_done_q;
    assign axi.bready  = (state_q == StB);

    assign unused_sigs = ^{axi.rid, axi.rlast, axi.bid, inst_sram_addr[2:0], data_sram_addr[2:0]};

    always_comb begin
        state_d      = state_q;
        req_id_d     = req_id_q;
        req_addr_d   = req_addr_q;
        req_strb_d   = req_strb_q;
        req_wdata_d  = req_wdata_q;
        req_data_d   = req_data_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        axi_err_d    = axi_err_q;
        aw_ok        = 1'b0;
        w_ok         = 1'b0;

        // A released stall ends the pipeline cycle; nothing can complete in that cycle.
        if (!stallreq_axi) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (data_pend) begin
                    req_data_d  = 1'b1;
                    req_id_d    = DATA_ID;
                    req_addr_d  = {data_sram_addr[ADDR_WD-1:3], 3'b000};
                    req_strb_d  = data_sram_we;
                    req_wdata_d = data_sram_wdata;
                    state_d     = (data_sram_we == '0) ? StRd : StWr;
                end else if (inst_pend) begin
                    req_data_d  = 1'b0;
                    req_id_d    = INST_ID;
                    req_addr_d  = {inst_sram_addr[ADDR_WD-1:3], 3'b000};
                    req_strb_d  = '0;
                    req_wdata_d = '0;
                    state_d     = StRd;
                end
            end
            StRd: begin
                if (axi.arvalid && axi.arready) ar_done_d = 1'b1;
                if (axi.rvalid && axi.rready) begin
                    if (req_data_q) begin
                        data_rdata_d = axi.rdata;
                        data_done_d  = 1'b1;
                    end else begin
                        inst_rdata_d = axi.rdata;
                        inst_done_d  = 1'b1;
                    end
                    if (axi.rresp != 2'b00) axi_err_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StWr: begin
                // When a channel is already done its valid is low, so ready is irrelevant.
                aw_ok = aw_done_q | axi.awready;
                w_ok  = w_done_q | axi.wready;
                if (axi.awvalid && axi.awready) aw_done_d = 1'b1;
                if (axi.wvalid && axi.wready) w_done_d = 1'b1;
                if (aw_ok && w_ok) state_d = StB;
            end
            StB: begin
                if (axi.bvalid) begin
                    data_done_d = 1'b1;
                    if (axi.bresp != 2'b00) axi_err_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_id_q     <= '0;
            req_addr_q   <= '0;
            req_strb_q   <= '0;
            req_wdata_q  <= '0;
            req_data_q   <= 1'b0;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            axi_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_id_q     <= req_id_d;
            req_addr_q   <= req_addr_d;
            req_strb_q   <= req_strb_d;
            req_wdata_q  <= req_wdata_d;
            req_data_q   <= req_data_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            axi_err_q    <= axi_err_d;
        end
    end
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter with a small configurable AXI slave model.
module tb_sram_axi_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        inst_en, data_en, stall, axi_err;
    logic [63:0] inst_addr, data_addr, data_wdata, inst_rdata, data_rdata;
    logic [7:0]  data_we;

    sram_axi_arbiter_if #(.ADDR_WD(64), .DATA_WD(64)) axi ();

    sram_axi_arbiter #(
        .ADDR_WD(64), .DATA_WD(64), .INST_ID(4'd0), .DATA_ID(4'd1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_sram_en    (inst_en),
        .inst_sram_addr  (inst_addr),
        .inst_sram_rdata (inst_rdata),
        .data_sram_en    (data_en),
        .data_sram_we    (data_we),
        .data_sram_addr  (data_addr),
        .data_sram_wdata (data_wdata),
        .data_sram_rdata (data_rdata),
        .stallreq_axi    (stall),
        .axi_err         (axi_err),
        .axi             (axi)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration
    logic [63:0] r_data_cfg;
    logic [1:0]  r_resp_cfg, b_resp_cfg;
    int          aw_delay, aw_wait;
    bit          aw_seen, w_seen;

    // Handshake monitor, sampled at the active edge
    int          cyc = 0;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int          ar_cnt, aw_cnt, ar_time, aw_time, b_first;
    int          arv_cycles, awv_cycles, wv_cycles;
    logic [63:0] last_araddr, last_awaddr, last_wdata;
    logic [3:0]  last_arid, last_awid;
    logic [7:0]  last_wstrb;

    always @(posedge clk) begin
        ar_hs = axi.arvalid & axi.arready;
        r_hs  = axi.rvalid & axi.rready;
        aw_hs = axi.awvalid & axi.awready;
        w_hs  = axi.wvalid & axi.wready;
        b_hs  = axi.bvalid & axi.bready;
        if (axi.arvalid === 1'b1) arv_cycles++;
        if (axi.awvalid === 1'b1) awv_cycles++;
        if (axi.wvalid === 1'b1) wv_cycles++;
        if (ar_hs) begin
            ar_cnt++; ar_time = cyc; last_araddr = axi.araddr; last_arid = axi.arid;
        end
        if (aw_hs) begin
            aw_cnt++; aw_time = cyc; last_awaddr = axi.awaddr; last_awid = axi.awid;
        end
        if (w_hs) begin
            last_wdata = axi.wdata; last_wstrb = axi.wstrb;
        end
        if (axi.bready === 1'b1 && b_first < 0) b_first = cyc;
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rid = 0;
            axi.rlast = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
            axi.bid = 0; aw_seen = 0; w_seen = 0; aw_wait = 0;
        end else begin
            axi.arready = 1'b1;
            if (r_hs) axi.rvalid = 1'b0;
            if (ar_hs) begin
                axi.rvalid = 1'b1; axi.rdata = r_data_cfg; axi.rresp = r_resp_cfg;
                axi.rid = last_arid; axi.rlast = 1'b1;
            end
            if (b_hs) axi.bvalid = 1'b0;
            if (aw_hs) begin aw_seen = 1; aw_wait = 0; end
            if (w_hs) w_seen = 1;
            if (aw_seen && w_seen) begin
                axi.bvalid = 1'b1; axi.bresp = b_resp_cfg; axi.bid = last_awid;
                aw_seen = 0; w_seen = 0;
            end
            axi.awready = axi.awvalid && (aw_wait >= aw_delay);
            if (axi.awvalid && !axi.awready) aw_wait++;
            axi.wready = axi.wvalid;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ar_cnt = 0; aw_cnt = 0; ar_time = -1; aw_time = -1; b_first = -1;
        arv_cycles = 0; awv_cycles = 0; wv_cycles = 0;
    endtask

    // Counts stall cycles starting from the current (request) cycle
    task automatic wait_release(input string tag, output int n);
        n = 0;
        while (stall && n < 50) begin
            step();
            n++;
        end
        check({tag, "_released"}, stall, 0);
    endtask

    int n;

    initial begin
        inst_en = 0; inst_addr = 0; data_en = 0; data_we = 0; data_addr = 0; data_wdata = 0;
        r_data_cfg = 0; r_resp_cfg = 0; b_resp_cfg = 0; aw_delay = 0;
        clear_mon();
        rst_n = 0;
        repeat (3) step();
        check("rst_stall", stall, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);
        check("rst_axi_err", axi_err, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_awid", axi.awid, 0);
        rst_n = 1;
        step();

        // Inst-only fetch, zero-wait slave
        clear_mon();
        r_data_cfg = 64'h1122_3344_5566_7788;
        inst_en = 1; inst_addr = 64'h8000_0004;
        #1;
        check("t1_req_stall", stall, 1);
        wait_release("t1", n);
        check("t1_stall_cycles", n, 3);
        check("t1_araddr", last_araddr, 64'h8000_0000);
        check("t1_arid", last_arid, 0);
        check("t1_rdata", inst_rdata, 64'h1122_3344_5566_7788);
        check("t1_ar_cnt", ar_cnt, 1);
        inst_en = 0;
        step();

        // Simultaneous store and fetch: data first
        clear_mon();
        r_data_cfg = 64'hCAFE_F00D;
        data_en = 1; data_we = 8'h0F; data_addr = 64'h100; data_wdata = 64'hAABB;
        inst_en = 1; inst_addr = 64'h200;
        #1;
        wait_release("t2", n);
        check("t2_stall_cycles", n, 6);
        check("t2_awid", last_awid, 1);
        check("t2_awaddr", last_awaddr, 64'h100);
        check("t2_wstrb", last_wstrb, 8'h0F);
        check("t2_wdata", last_wdata, 64'hAABB);
        check("t2_araddr", last_araddr, 64'h200);
        check("t2_arid", last_arid, 0);
        check("t2_aw_before_ar", aw_time < ar_time, 1);
        check("t2_inst_rdata", inst_rdata, 64'hCAFE_F00D);
        check("t2_data_rdata_kept", data_rdata, 0);
        check("t2_aw_cnt", aw_cnt, 1);
        inst_en = 0; data_en = 0;
        step();

        // AW backpressure of 3 cycles, W immediate
        clear_mon();
        aw_delay = 3;
        data_en = 1; data_we = 8'hFF; data_addr = 64'h308; data_wdata = 64'h0123_4567_89AB_CDEF;
        #1;
        wait_release("t3", n);
        check("t3_stall_cycles", n, 6);
        check("t3_awvalid_cycles", awv_cycles, 4);
        check("t3_wvalid_cycles", wv_cycles, 1);
        check("t3_bready_after_aw", b_first > aw_time, 1);
        check("t3_awaddr", last_awaddr, 64'h308);
        data_en = 0; aw_delay = 0;
        step();

        // SLVERR on a load, then a clean load
        clear_mon();
        r_data_cfg = 64'hDEAD_BEEF_0000_0001; r_resp_cfg = 2'b10;
        data_en = 1; data_we = 0; data_addr = 64'h410;
        #1;
        wait_release("t4a", n);
        check("t4a_stall_cycles", n, 3);
        check("t4a_data_rdata", data_rdata, 64'hDEAD_BEEF_0000_0001);
        check("t4a_axi_err", axi_err, 1);
        check("t4a_arid", last_arid, 1);
        data_en = 0;
        step();
        r_resp_cfg = 2'b00; r_data_cfg = 64'h55;
        data_en = 1; data_addr = 64'h41F;
        #1;
        wait_release("t4b", n);
        check("t4b_data_rdata", data_rdata, 64'h55);
        check("t4b_araddr", last_araddr, 64'h418);
        check("t4b_axi_err_sticky", axi_err, 1);
        data_en = 0;
        step();

        // Reset while in RD
        clear_mon();
        inst_en = 1; inst_addr = 64'h500;
        step();
        check("t5_arvalid", axi.arvalid, 1);
        rst_n = 0;
        step();
        check("t5_arvalid_rst", axi.arvalid, 0);
        check("t5_rready_rst", axi.rready, 0);
        check("t5_inst_rdata_rst", inst_rdata, 0);
        check("t5_data_rdata_rst", data_rdata, 0);
        check("t5_axi_err_rst", axi_err, 0);
        check("t5_stall_en", stall, 1);
        inst_en = 0;
        #1;
        check("t5_stall_noen", stall, 0);
        rst_n = 1;
        step();
        step();

        // Enable held across the release edge
        clear_mon();
        r_data_cfg = 64'h600D;
        inst_en = 1; inst_addr = 64'h600;
        #1;
        wait_release("t6a", n);
        check("t6a_stall_cycles", n, 3);
        check("t6a_ar_cnt", ar_cnt, 1);
        check("t6a_rdata", inst_rdata, 64'h600D);
        step();
        check("t6_rerequest_stall", stall, 1);
        wait_release("t6b", n);
        check("t6b_stall_cycles", n, 3);
        check("t6b_ar_cnt", ar_cnt, 2);
        check("t6b_araddr", last_araddr, 64'h600);
        inst_en = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
